// File: rtl/data_mem_access_unit_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_encode_def
//   Shared encodings for the memory stage: access-size codes carried by the
//   decoder's MemOp field, the access unit's FSM states and the fault causes
//   it can report, plus a helper that classifies a request's fault cause.
// ----------------------------------------------------------------------------
package ctrl_encode_def;

    // MemOp access-size encodings
    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_BYTE = 2'b10;
    localparam logic [1:0] MEM_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } dmau_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_RESERVED = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } fault_cause_e;

    // Classify a request before any bus activity: reserved size code or an
    // address that is not naturally aligned for the access size.
    function automatic fault_cause_e req_fault_cause(input logic [1:0] op,
                                                     input logic [1:0] off);
        fault_cause_e cause;
        cause = CAUSE_NONE;
        case (op)
            MEM_WORD: if (off != 2'b00) cause = CAUSE_MISALIGN;
            MEM_HALF: if (off[0])       cause = CAUSE_MISALIGN;
            MEM_BYTE: cause = CAUSE_NONE;
            default:  cause = CAUSE_RESERVED;
        endcase
        return cause;
    endfunction

endpackage

// File: rtl/data_mem_access_unit_lane_format.sv
// ----------------------------------------------------------------------------
// mem_lane_format
//   Purely combinational lane logic for a 32-bit little-endian word bus.
//   Ports:
//     op        in   2   access size (MEM_WORD / MEM_HALF / MEM_BYTE)
//     ext       in   1   load extension: 1 = sign, 0 = zero
//     offset    in   2   byte offset within the word (addr[1:0])
//     wdata     in  32   right-justified store data
//     rdata_raw in  32   raw word from the bus
//     be        out  4   byte-lane enables, lane 0 = bits 7:0
//     wdata_rep out 32   store data replicated across all lanes
//     rdata_fmt out 32   selected lane(s), extended to 32 bits
//   The reserved size code yields all-zero outputs.
// ----------------------------------------------------------------------------
module mem_lane_format
    import ctrl_encode_def::*;
(
    input  logic [1:0]  op,
    input  logic        ext,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_fmt
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfwords are only legal at offsets 0 and 2, so offset[1] picks the half.
    assign byte_sel = rdata_raw[{offset, 3'b000} +: 8];
    assign half_sel = rdata_raw[{offset[1], 4'b0000} +: 16];

    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata_fmt = 32'h0;
        case (op)
            MEM_BYTE: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_fmt = {{24{ext & byte_sel[7]}}, byte_sel};
            end
            MEM_HALF: begin
                be        = 4'b0011 << offset;
                wdata_rep = {2{wdata[15:0]}};
                rdata_fmt = {{16{ext & half_sel[15]}}, half_sel};
            end
            MEM_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_fmt = rdata_raw;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = 32'h0;
                rdata_fmt = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// ----------------------------------------------------------------------------
// data_mem_access_unit
//   Memory-stage responder: turns one load/store request from the core into a
//   single word-bus transaction, then reports completion with a one-cycle
//   done pulse carrying the formatted load data and an error flag.
//   Ports:
//     clk, rstn            clock (rising edge), async active-low reset
//     req_valid            core request strobe (sampled only in IDLE)
//     MemOp/MemExt/MemWrite access size, load extension, store select
//     addr, wdata          byte address, right-justified store data
//     busy                 high in ISSUE and RESP; core stalls
//     done                 one-cycle completion pulse
//     rdata, err           result and fault flag; update with done, then hold
//     mem_req/mem_we/mem_addr/mem_be/mem_wdata   word-bus request side
//     mem_rdata, mem_ack   word-bus response side
//     dbg_state, dbg_cause FSM state and cause of the last completed access
//
//   Handshake: a request is accepted on a rising edge where req_valid=1 and
//   the unit is IDLE; req_valid at any other time is ignored. On the bus,
//   mem_req and all mem_* request fields stay constant until a rising edge
//   that samples mem_ack=1 (or the timeout expires); mem_ack is ignored
//   whenever mem_req=0.
// ----------------------------------------------------------------------------
module data_mem_access_unit
    import ctrl_encode_def::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
)(
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    input  logic [1:0]        MemOp,
    input  logic              MemExt,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        dbg_state,
    output logic [1:0]        dbg_cause
);

    // Counter value on the last ISSUE cycle before the timeout fires.
    localparam logic [31:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    dmau_state_e       state_q, state_d;
    fault_cause_e      req_cause;
    fault_cause_e      cause_q;

    logic [1:0]        op_q;
    logic              ext_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       cnt_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              timeout_hit;

    logic [3:0]        be_fmt;
    logic [31:0]       wdata_fmt;
    logic [31:0]       rdata_fmt;

    assign req_cause   = req_fault_cause(MemOp, addr[1:0]);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    mem_lane_format u_lane_format (
        .op        (op_q),
        .ext       (ext_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata_raw (mem_rdata),
        .be        (be_fmt),
        .wdata_rep (wdata_fmt),
        .rdata_fmt (rdata_fmt)
    );

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- next state and outputs ----------------
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = (req_cause != CAUSE_NONE) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_be    = be_fmt;
                mem_wdata = wdata_fmt;
                // An ack on the final allowed cycle still wins over timeout.
                if (mem_ack || timeout_hit) state_d = ST_RESP;
            end
            ST_RESP: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- request capture, counter, result ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q    <= MEM_WORD;
            ext_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            cnt_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= MemOp;
                        ext_q   <= MemExt;
                        we_q    <= MemWrite;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt_q   <= 32'h0;
                        // A faulting request completes without touching the bus.
                        if (req_cause != CAUSE_NONE) begin
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                            cause_q <= req_cause;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (mem_ack) begin
                        rdata_q <= we_q ? 32'h0 : rdata_fmt;
                        err_q   <= 1'b0;
                        cause_q <= CAUSE_NONE;
                    end else if (timeout_hit) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign err       = err_q;
    assign dbg_state = state_q;
    assign dbg_cause = cause_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rstn;
    always #5 clk = ~clk;

    logic        req_valid;
    logic [1:0]  MemOp;
    logic        MemExt;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_cause;

    data_mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .MemOp     (MemOp),
        .MemExt    (MemExt),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .dbg_state (dbg_state),
        .dbg_cause (dbg_cause)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];      // {err, rdata} expected at each done
    logic [68:0] bus_q[$];      // {we, addr, be, wdata} expected while mem_req

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rstn) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got err=%0b rdata=%0h want no done", err, rdata);
                end else begin
                    check("resp", {63'h0, err, rdata}, {63'h0, exp_q.pop_front()});
                end
            end
            if (mem_req) begin
                if (bus_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_mem_req: got addr=%0h be=%0h want no request", mem_addr, mem_be);
                end else begin
                    check("bus_fields", {27'h0, mem_we, mem_addr, mem_be, mem_wdata}, {27'h0, bus_q[0]});
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Issues one request, acts as the bus (ack on the ack_wait-th mem_req
    // cycle, 0 = never), and checks busy, latency and mem_req duration.
    task automatic access(input string name, input logic [1:0] op, input logic ext,
                          input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input int ack_wait, input logic [31:0] rd,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input int exp_req);
        int  n_req;
        int  lat;
        bit  seen;
        exp_q.push_back({exp_err, exp_rd});
        if (exp_req != 0) bus_q.push_back({we, a[31:2], 2'b00, exp_be, exp_wd});
        @(negedge clk);
        MemOp = op; MemExt = ext; MemWrite = we; addr = a; wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check({name, "_busy"}, {95'h0, busy}, 96'h1);
        n_req = 0; lat = 1; seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            mem_ack = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (mem_req) begin
                n_req++;
                mem_ack   = (n_req == ack_wait);
                mem_rdata = mem_ack ? rd : 32'h0;
            end
            @(negedge clk);
            lat++;
        end
        mem_ack = 1'b0;
        check({name, "_done_seen"}, {95'h0, seen}, 96'h1);
        check({name, "_latency"}, 96'(lat), (exp_req != 0) ? 96'(exp_req + 1) : 96'd1);
        check({name, "_req_cycles"}, 96'(n_req), 96'(exp_req));
        if (exp_req != 0 && bus_q.size() != 0) void'(bus_q.pop_front());
        @(negedge clk);
        check({name, "_idle_after"}, {94'h0, busy, done}, 96'h0);
        check({name, "_hold"}, {63'h0, err, rdata}, {63'h0, exp_err, exp_rd});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn = 1'b0; req_valid = 1'b0; MemOp = 2'b00; MemExt = 1'b0; MemWrite = 1'b0;
        addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        #1;
        check("reset_outputs", {busy, done, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata},
              {4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0});
        check("reset_state", {94'h0, dbg_state}, 96'h0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;

        //     name        op     ext  we    addr          wdata         ack rd            err   exp_rd        be    exp_wd        req
        access("wstore",   2'b00, 0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 3, 32'h0,        1'b0, 32'h0,        4'hF, 32'hDEAD_BEEF, 3);
        access("bload_s",  2'b10, 1, 1'b0, 32'h0000_2003, 32'h0,         1, 32'h8011_2233, 1'b0, 32'hFFFF_FF80, 4'h8, 32'h0,        1);
        access("bload_z",  2'b10, 0, 1'b0, 32'h0000_2003, 32'h0,         1, 32'h8011_2233, 1'b0, 32'h0000_0080, 4'h8, 32'h0,        1);
        access("hstore",   2'b01, 0, 1'b1, 32'h0000_2002, 32'h0000_ABCD, 2, 32'h0,        1'b0, 32'h0,        4'hC, 32'hABCD_ABCD, 2);
        access("hload_s",  2'b01, 1, 1'b0, 32'h0000_2002, 32'h0,         1, 32'h8001_1234, 1'b0, 32'hFFFF_8001, 4'hC, 32'h0,        1);
        access("hload_z",  2'b01, 0, 1'b0, 32'h0000_2000, 32'h0,         1, 32'h1234_F00D, 1'b0, 32'h0000_F00D, 4'h3, 32'h0,        1);
        access("bload_o1", 2'b10, 0, 1'b0, 32'h0000_1001, 32'h0,         1, 32'h0000_FF00, 1'b0, 32'h0000_00FF, 4'h2, 32'h0,        1);
        access("bstore",   2'b10, 0, 1'b1, 32'h0000_0005, 32'h1234_56AB, 1, 32'h0,        1'b0, 32'h0,        4'h2, 32'hABAB_ABAB, 1);
        access("wload_l",  2'b00, 1, 1'b0, 32'h0000_0010, 32'h0,         4, 32'h8765_4321, 1'b0, 32'h8765_4321, 4'hF, 32'h0,        4);
        access("mis_word", 2'b00, 0, 1'b0, 32'h0000_3001, 32'h0,         1, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0,        0);
        access("mis_half", 2'b01, 1, 1'b0, 32'h0000_2001, 32'h0,         1, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0,        0);
        access("rsvd_op",  2'b11, 0, 1'b1, 32'h0000_4000, 32'h5555_5555, 1, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0,        0);
        access("wload_ok", 2'b00, 0, 1'b0, 32'h0000_0020, 32'h0,         1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 4'hF, 32'h0,        1);
        access("timeout",  2'b00, 0, 1'b0, 32'h0000_4000, 32'h0,         0, 32'h0,        1'b1, 32'h0,        4'hF, 32'h0,        4);

        // Late ack after the timeout must be ignored.
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        check("late_ack_busy", {94'h0, busy, mem_req}, 96'h0);
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_idle", {94'h0, busy, done}, 96'h0);
        check("late_ack_result", {63'h0, err, rdata}, {63'h0, 1'b1, 32'h0});

        // Reset while a transaction is on the bus (ack never arrives).
        bus_q.push_back({1'b0, 32'h0000_6000, 4'hF, 32'h0});
        @(negedge clk);
        MemOp = 2'b00; MemExt = 1'b0; MemWrite = 1'b0; addr = 32'h0000_6000; wdata = 32'h0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_req", {95'h0, mem_req}, 96'h1);
        #2 rstn = 1'b0;
        #1;
        check("async_reset_drop", {busy, done, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0});
        void'(bus_q.pop_front());
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {94'h0, busy, mem_req}, 96'h0);
        access("after_rst", 2'b10, 0, 1'b0, 32'h0000_0000, 32'h0, 1, 32'h0000_007F, 1'b0, 32'h0000_007F, 4'h1, 32'h0, 1);

        repeat (3) @(negedge clk);
        check("queues_drained", 96'(exp_q.size() + bus_q.size()), 96'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound in case the design wedges outside the bounded loops.
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
